// File: rtl/rx_bit_timer.sv
// Bit-period timer and bit-unstuffer for the serial receive path.
// Drives shift_enable for the receive shift register and flags byte completion and stuffing errors.
module rx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT  = 8,
  parameter int unsigned SAMPLE_POINT  = 3,
  parameter int unsigned BITS_PER_BYTE = 8,
  parameter int unsigned STUFF_RUN     = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_timer,
  input  logic d_orig,
  input  logic resync,
  output logic shift_enable,
  output logic byte_received,
  output logic stuff_error
);

  localparam int unsigned CNT_W  = (CLKS_PER_BIT  > 1) ? $clog2(CLKS_PER_BIT)  : 1;
  localparam int unsigned BIT_W  = (BITS_PER_BYTE > 1) ? $clog2(BITS_PER_BYTE) : 1;
  localparam int unsigned ONES_W = (STUFF_RUN     > 0) ? $clog2(STUFF_RUN + 1) : 1;

  logic [CNT_W-1:0]  clk_cnt,  clk_cnt_nxt;
  logic [BIT_W-1:0]  bit_cnt,  bit_cnt_nxt;
  logic [ONES_W-1:0] ones_cnt, ones_cnt_nxt;
  logic              byte_pend, byte_pend_nxt;
  logic              shift_nxt, stuff_err_nxt;
  logic              sample, stuffed;

  // Next-state for counters and the pulses that follow a sample event
  always_comb begin
    clk_cnt_nxt   = clk_cnt;
    bit_cnt_nxt   = bit_cnt;
    ones_cnt_nxt  = ones_cnt;
    byte_pend_nxt = 1'b0;
    shift_nxt     = 1'b0;
    stuff_err_nxt = 1'b0;
    sample        = enable_timer && (clk_cnt == CNT_W'(SAMPLE_POINT));
    stuffed       = (ones_cnt == ONES_W'(STUFF_RUN));

    if (!enable_timer) begin
      clk_cnt_nxt  = '0;
      bit_cnt_nxt  = '0;
      ones_cnt_nxt = '0;
    end else begin
      // The resync cycle itself is phase 0, so the following cycle is phase 1
      if (resync) begin
        clk_cnt_nxt = CNT_W'(1);
      end else if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
        clk_cnt_nxt = '0;
      end else begin
        clk_cnt_nxt = clk_cnt + CNT_W'(1);
      end

      if (sample) begin
        if (stuffed) begin
          ones_cnt_nxt  = '0;
          stuff_err_nxt = d_orig;
        end else begin
          shift_nxt    = 1'b1;
          ones_cnt_nxt = d_orig ? (ones_cnt + ONES_W'(1)) : '0;
          if (bit_cnt == BIT_W'(BITS_PER_BYTE - 1)) begin
            bit_cnt_nxt   = '0;
            byte_pend_nxt = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end
    end
  end

  // byte_received trails the last shift by one cycle so the shift register has captured the bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      ones_cnt      <= '0;
      byte_pend     <= 1'b0;
      shift_enable  <= 1'b0;
      stuff_error   <= 1'b0;
      byte_received <= 1'b0;
    end else begin
      clk_cnt       <= clk_cnt_nxt;
      bit_cnt       <= bit_cnt_nxt;
      ones_cnt      <= ones_cnt_nxt;
      byte_pend     <= byte_pend_nxt;
      shift_enable  <= shift_nxt;
      stuff_error   <= stuff_err_nxt;
      byte_received <= byte_pend & enable_timer;
    end
  end

endmodule
